flash_xip: RTL

//  Execute-in-place SPI NOR flash read controller; next generation of the single-mode flash reader.

---
 rtl/flash_pkg.sv | 40 ++++
 rtl/flash_sclk_gen.sv | 42 ++++
 rtl/flash_xip.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the execute-in-place SPI NOR flash read controller.
// Contents: read-mode encoding, command opcodes, controller state type and
// counter-width helpers used by flash_xip and flash_sclk_gen.
package flash_pkg;

    typedef enum logic [1:0] {
        MODE_READ        = 2'd0,
        MODE_FAST_READ   = 2'd1,
        MODE_DUAL_OUTPUT = 2'd2
    } mode_e;

    localparam logic [7:0] OP_READ        = 8'h03;
    localparam logic [7:0] OP_FAST_READ   = 8'h0B;
    localparam logic [7:0] OP_DUAL_OUTPUT = 8'h3B;

    // ST_GAP keeps CS high for one SCLK period before re-issuing a command
    // when a non-sequential read interrupts an open burst.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DONE,
        ST_HOLD
    } state_e;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [7:0] opcode_for(input int mode);
        if (mode == int'(MODE_FAST_READ))   return OP_FAST_READ;
        if (mode == int'(MODE_DUAL_OUTPUT)) return OP_DUAL_OUTPUT;
        return OP_READ;
    endfunction

endpackage

// File: rtl/flash_sclk_gen.sv
// SCLK generator: toggles clk_out every CLK_DIV clk cycles while enabled.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   enable      run the divider; when low clk_out is held low and the
//               phase counter restarts, so the first edge is always a rise
//   clk_out     registered SCLK
//   rise, fall  strobes valid in the cycle before clk_out rises / falls
module flash_sclk_gen
    import flash_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic clk_out,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          last;

    assign last = (cnt == CW'(CLK_DIV - 1));
    assign rise = enable & last & ~clk_out;
    assign fall = enable & last & clk_out;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (last) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/flash_xip.sv
// Execute-in-place SPI NOR flash read controller (SPI mode 0).
// Serves 32-bit word reads from the CPU bus using READ 03h, FAST_READ 0Bh
// or DUAL_OUTPUT 3Bh; keeps CS low after a read so that a read of the next
// word continues the burst without re-sending command and address.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   clk_out, csn_out      SCLK and active-low chip select (registered)
//   io0_in, io1_in        pad inputs (io1 = MISO, io0 also data in dual mode)
//   io0_en/io1_en         pad output enables
//   io0_out/io1_out       pad outputs (io1 never driven)
//   address_in            byte address, word aligned
//   sel_in, read_in       bus select / read strobe
//   write_mask_in/value   writes are acknowledged and discarded
//   read_value_out        read data, zero when not selected
//   ready_out             single-cycle completion pulse
module flash_xip
    import flash_pkg::*;
#(
    parameter int MODE         = 0,
    parameter int ADDR_BITS    = 24,
    parameter int DUMMY_CYCLES = 8,
    parameter int CLK_DIV      = 1,
    parameter int HOLD_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        clk_out,
    output logic        csn_out,
    input  logic        io0_in,
    input  logic        io1_in,
    output logic        io0_en,
    output logic        io1_en,
    output logic        io0_out,
    output logic        io1_out,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out
);

    localparam int D         = (MODE == 0) ? 0 : DUMMY_CYCLES;
    localparam int W         = (MODE == 2) ? 2 : 1;
    localparam int DATA_BITS = 32 / W;
    localparam int MAX_BITS  = (ADDR_BITS > 32) ? ADDR_BITS : ((D > 32) ? D : 32);
    localparam int BW        = cnt_width(MAX_BITS);
    localparam int GW        = cnt_width(2 * CLK_DIV);
    localparam int HW        = cnt_width(HOLD_CYCLES);
    localparam logic [7:0] OPCODE = opcode_for(MODE);

    state_e               state;
    logic [31:0]          sr;          // command/address out, data in
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        phase_last;
    logic [GW-1:0]        gap_cnt;
    logic [HW-1:0]        hold_cnt;
    logic [ADDR_BITS-1:0] cur_addr;
    logic [ADDR_BITS-1:0] next_addr;
    logic [ADDR_BITS-1:0] req_addr;
    logic                 seq_valid;
    logic [31:0]          rdata;
    logic                 sclk_en, rise, fall;
    logic                 rd_req, wr_req, seq_hit;
    logic                 unused;

    assign unused   = ^{write_value_in, address_in};
    assign io1_en   = 1'b0;
    assign io1_out  = 1'b0;
    assign rd_req   = sel_in & read_in;
    assign wr_req   = sel_in & (|write_mask_in) & ~read_in;
    assign req_addr = {address_in[ADDR_BITS-1:2], 2'b00};
    assign seq_hit  = seq_valid && (req_addr == next_addr);
    assign sclk_en  = (state == ST_CMD) || (state == ST_ADDR) ||
                      (state == ST_DUMMY) || (state == ST_DATA);
    assign read_value_out = sel_in ? rdata : 32'h0;

    flash_sclk_gen #(.CLK_DIV(CLK_DIV)) sclk_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (sclk_en),
        .clk_out (clk_out),
        .rise    (rise),
        .fall    (fall)
    );

    always_comb begin
        phase_last = '0;
        case (state)
            ST_CMD:   phase_last = BW'(7);
            ST_ADDR:  phase_last = BW'(ADDR_BITS - 1);
            ST_DUMMY: phase_last = BW'((D > 0) ? D - 1 : 0);
            ST_DATA:  phase_last = BW'(DATA_BITS - 1);
            default:  phase_last = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            csn_out   <= 1'b1;
            io0_en    <= 1'b1;
            io0_out   <= 1'b0;
            ready_out <= 1'b0;
            seq_valid <= 1'b0;
            sr        <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            hold_cnt  <= '0;
            cur_addr  <= '0;
            next_addr <= '0;
            rdata     <= '0;
        end else begin
            ready_out <= 1'b0;
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (rd_req) begin
                        cur_addr <= req_addr;
                        bit_cnt  <= '0;
                        if (state == ST_HOLD && seq_hit) begin
                            // Burst continuation: flash is already streaming
                            // the next word, go straight to data.
                            state  <= ST_DATA;
                            io0_en <= (W != 2);
                        end else if (state == ST_HOLD) begin
                            state     <= ST_GAP;
                            csn_out   <= 1'b1;
                            gap_cnt   <= '0;
                            seq_valid <= 1'b0;
                        end else begin
                            state   <= ST_CMD;
                            csn_out <= 1'b0;
                            sr      <= {OPCODE, 24'h0};
                            io0_out <= OPCODE[7];
                        end
                    end else begin
                        if (wr_req) ready_out <= 1'b1;
                        if (state == ST_HOLD) begin
                            if (hold_cnt == HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0)) begin
                                state     <= ST_IDLE;
                                csn_out   <= 1'b1;
                                seq_valid <= 1'b0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(2 * CLK_DIV - 1)) begin
                        state   <= ST_CMD;
                        csn_out <= 1'b0;
                        sr      <= {OPCODE, 24'h0};
                        io0_out <= OPCODE[7];
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                    if (rise && state == ST_DATA) begin
                        if (W == 2) sr <= {sr[29:0], io1_in, io0_in};
                        else        sr <= {sr[30:0], io1_in};
                    end
                    if (fall) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (state == ST_CMD || state == ST_ADDR) begin
                            sr      <= {sr[30:0], 1'b0};
                            io0_out <= sr[30];
                        end
                        if (bit_cnt == phase_last) begin
                            bit_cnt <= '0;
                            case (state)
                                ST_CMD: begin
                                    state   <= ST_ADDR;
                                    sr      <= 32'(cur_addr) << (32 - ADDR_BITS);
                                    io0_out <= cur_addr[ADDR_BITS-1];
                                end
                                ST_ADDR: begin
                                    io0_out <= 1'b0;
                                    if (D > 0) begin
                                        state <= ST_DUMMY;
                                    end else begin
                                        state  <= ST_DATA;
                                        io0_en <= (W != 2);
                                    end
                                end
                                ST_DUMMY: begin
                                    state  <= ST_DATA;
                                    io0_en <= (W != 2);
                                end
                                default: state <= ST_DONE;
                            endcase
                        end
                    end
                end
                ST_DONE: begin
                    // Bytes arrive MSB-first in order; first byte lands in [7:0].
                    rdata     <= {sr[7:0], sr[15:8], sr[23:16], sr[31:24]};
                    ready_out <= 1'b1;
                    io0_en    <= 1'b1;
                    if (HOLD_CYCLES > 0) begin
                        state     <= ST_HOLD;
                        hold_cnt  <= '0;
                        seq_valid <= 1'b1;
                        next_addr <= cur_addr + ADDR_BITS'(4);
                    end else begin
                        state   <= ST_IDLE;
                        csn_out <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
